exception_controller: RTL
=========================

Name: exception_controller

Overview:
Sequential consumer of the combinational exception flag produced by the exception-detect stage from ovf/opcode. On a flagged exception it latches the faulting PC and cause, then flushes the pipeline for a fixed number of cycles. It then redirects the PC to the handler vector and tracks handler residency until an ERET returns control to the saved PC. It sits between exception detection and the PC-select mux / pipeline-register flush controls.

Parameters:
PC_WIDTH, 32, width of PC, EPC and target buses
HANDLER_VECTOR, 32'h0000_0080, fixed handler entry address
FLUSH_CYCLES, 2, cycles flush/stall held before redirect; legal range 1..15

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
exception_in  input  1  exception flag from exception-detect stage
ovf  input  1  raw overflow flag, sampled as cause
opcode  input  1  raw illegal-opcode flag, sampled as cause
pc_in  input  PC_WIDTH  PC of instruction presenting exception_in
eret  input  1  return-from-exception decoded this cycle
flush  output  1  clear IF/ID/EX pipeline registers
stall  output  1  freeze PC register
pc_sel  output  1  1 = PC mux takes pc_target
pc_target  output  PC_WIDTH  redirect address
epc  output  PC_WIDTH  saved exception PC
cause  output  2  {opcode, ovf} captured at exception
exc_active  output  1  handler in progress
double_fault  output  1  sticky: exception seen while in handler

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst. While rst=1 all outputs are 0, epc=0, cause=2'b00, state=IDLE, counter=0.
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN. All outputs are registered or decoded from state only; no input-to-output combinational path.
- IDLE: all control outputs 0.
  - exception_in=1 at an edge: epc<=pc_in, cause<={opcode,ovf}, cnt<=FLUSH_CYCLES-1, next FLUSH.
  - exception_in=0 with ovf/opcode set: ignored.
  - eret in IDLE: ignored.
- FLUSH: flush=1, stall=1, pc_sel=0. Each edge cnt decrements. At cnt==0, next REDIRECT. FLUSH therefore lasts exactly FLUSH_CYCLES cycles.
- REDIRECT: one cycle. flush=1, stall=0, pc_sel=1, pc_target=HANDLER_VECTOR. Next HANDLER.
- HANDLER: exc_active=1, other control outputs 0, pc_target=0.
  - eret=1: next RETURN.
  - exception_in=1: double_fault<=1. epc and cause are not overwritten and the state is unchanged.
  - If exception_in and eret occur on the same edge, both actions are taken: double_fault set and next RETURN.
- RETURN: one cycle. pc_sel=1, pc_target=epc, flush=1, exc_active=0. Next IDLE.
- exception_in arriving in FLUSH, REDIRECT or RETURN is ignored: no capture, no double_fault.
- epc/cause hold their last captured value after return until the next capture. double_fault clears only on rst.
- rst asserted mid-sequence, in any state: immediate return to IDLE with reset values. No redirect is issued afterwards.
- Latency: from the capture edge, the first pc_sel=1 cycle is FLUSH_CYCLES+1 cycles later.

Test Plan:
- Overflow exception, FLUSH_CYCLES=2: pc_in=32'h0000_0040, ovf=1, exception_in=1 for one cycle.
  - Required: epc=0x40, cause=2'b01; flush=stall=1 for 2 cycles.
  - Then one cycle with pc_sel=1, pc_target=0x80, flush=1.
  - Then exc_active=1.
- Return path: from HANDLER, eret pulse.
  - Required: one cycle with pc_sel=1, pc_target=0x40, flush=1, exc_active=0; then IDLE with all controls 0.
  - epc remains 0x40.
- Both causes: opcode=1, ovf=1, exception_in=1, pc_in=0x100.
  - Required: cause=2'b11, epc=0x100.
- Nested exception in HANDLER: exception_in=1 with pc_in=0x200.
  - Required: double_fault=1 and sticky; epc stays 0x40; state remains HANDLER.
  - After eret, pc_target=0x40 and double_fault is still 1.
- Ignored events:
  - eret in IDLE: no output change.
  - exception_in during FLUSH: epc unchanged, redirect timing unchanged.
- Async reset mid-FLUSH: assert rst between clock edges.
  - Required: flush/stall drop immediately without waiting for an edge; epc=0; no pc_sel pulse follows.

Source files
------------

// File: rtl/exception_controller_if.sv
// Handshake bundle between exception detect, the exception controller and
// the PC-select / pipeline-flush consumers.
interface exception_controller_if #(
  parameter int PC_WIDTH = 32
);
  logic                exception_in;
  logic                ovf;
  logic                opcode;
  logic [PC_WIDTH-1:0] pc_in;
  logic                eret;
  logic                flush;
  logic                stall;
  logic                pc_sel;
  logic [PC_WIDTH-1:0] pc_target;
  logic [PC_WIDTH-1:0] epc;
  logic [1:0]          cause;
  logic                exc_active;
  logic                double_fault;

  modport master (
    output exception_in, ovf, opcode, pc_in, eret,
    input  flush, stall, pc_sel, pc_target,
    input  epc, cause, exc_active, double_fault
  );

  modport slave (
    input  exception_in, ovf, opcode, pc_in, eret,
    output flush, stall, pc_sel, pc_target,
    output epc, cause, exc_active, double_fault
  );
endinterface

// File: rtl/exception_controller.sv
// Exception sequencer: capture EPC/cause, flush, redirect to the handler,
// track handler residency and return to EPC on ERET.
module exception_controller #(
  parameter int                     PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0]    HANDLER_VECTOR = PC_WIDTH'(32'h0000_0080),
  parameter int                     FLUSH_CYCLES   = 2
) (
  input logic                 clk,
  input logic                 rst,
  exception_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    REDIRECT,
    HANDLER,
    RETURN
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t              state;
  state_t              next_state;
  logic [3:0]          cnt;
  logic [PC_WIDTH-1:0] epc_q;
  logic [1:0]          cause_q;
  logic                df_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      epc_q   <= '0;
      cause_q <= 2'b00;
      df_q    <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.exception_in) begin
        epc_q   <= bus.pc_in;
        cause_q <= {bus.opcode, bus.ovf};
        cnt     <= CNT_INIT;
      end else if (state == FLUSH && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // A fault inside the handler is only recorded; context is preserved.
      if (state == HANDLER && bus.exception_in) begin
        df_q <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (bus.exception_in) next_state = FLUSH;
      FLUSH:    if (cnt == 4'd0) next_state = REDIRECT;
      REDIRECT: next_state = HANDLER;
      HANDLER:  if (bus.eret) next_state = RETURN;
      RETURN:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.flush      = 1'b0;
    bus.stall      = 1'b0;
    bus.pc_sel     = 1'b0;
    bus.pc_target  = '0;
    bus.exc_active = 1'b0;
    case (state)
      FLUSH: begin
        bus.flush = 1'b1;
        bus.stall = 1'b1;
      end
      REDIRECT: begin
        bus.flush     = 1'b1;
        bus.pc_sel    = 1'b1;
        bus.pc_target = HANDLER_VECTOR;
      end
      HANDLER: begin
        bus.exc_active = 1'b1;
      end
      RETURN: begin
        bus.flush     = 1'b1;
        bus.pc_sel    = 1'b1;
        bus.pc_target = epc_q;
      end
      default: begin
      end
    endcase
  end

  assign bus.epc          = epc_q;
  assign bus.cause        = cause_q;
  assign bus.double_fault = df_q;

endmodule
